dma_h2c_axis_downsizer: RTL and testbench
=========================================

// Module: dma_h2c_axis_downsizer
// PURPOSE
// - Downstream consumer of the XDMA H2C AXI-stream (512-bit, tkeep/tparity/tusr).
// - Splits each accepted wide beat into OUT_W-bit words for narrow user logic (UART TX path).
// - Optionally checks per-byte parity on kept bytes.
// - Only sequential buffer between the DMA stream and the user clock-domain FIFO; same clock as the DMA.
// PARAMETERS
// - IN_W   512  input data width; multiple of OUT_W
// - OUT_W  64   output data width; multiple of 8
// - CNT_W  16   width of the parity error counter
// PORTS
// - axi_aclk         in   1          single clock; all logic on rising edge
// - axi_aresetn      in   1          synchronous, active-low reset
// - s_h2c_tdata      in   IN_W       H2C data, byte 0 at [7:0]
// - s_h2c_tparity    in   IN_W/8     per-byte parity
// - s_h2c_tkeep      in   IN_W/8     byte enables
// - s_h2c_tusr       in   IN_W/8     ignored
// - s_h2c_tlast      in   1          end of packet
// - s_h2c_tvalid     in   1          beat valid
// - s_h2c_tready     out  1          beat accepted when tvalid&tready
// - m_tdata          out  OUT_W      narrow word
// - m_tkeep          out  OUT_W/8    byte enables of the word
// - m_tlast          out  1          last word of packet
// - m_tvalid         out  1          word valid
// - m_tready         in   1          downstream ready
// - parity_err       out  1          one-cycle pulse on a parity mismatch
// - parity_err_cnt   out  CNT_W      saturating mismatch count
// BEHAVIOUR
// - Reset (axi_aresetn=0 at an edge), values after that edge:
//   - state=IDLE
//   - s_h2c_tready=0, then 1 from the first cycle out of reset
//   - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0
//   - parity_err=0, parity_err_cnt=0
//   - A beat held mid-packet is discarded; no partial words after reset.
// - FSM IDLE / EMIT. Words per beat: N = CEIL((h+1)*8/OUT_W), where h = index of the highest set tkeep bit.
// - IDLE:
//   - s_h2c_tready=1.
//   - On accept: register tdata, tkeep and tlast; compute N; chunk idx=0; go to EMIT.
// - EMIT:
//   - m_tvalid=1.
//   - m_tdata = held data[idx*OUT_W +: OUT_W]; m_tkeep = held tkeep[idx*OUT_W/8 +: OUT_W/8].
//   - m_tlast = held tlast AND (idx==N-1).
//   - Outputs stay stable while m_tvalid & !m_tready.
//   - Handshake with idx<N-1: idx increments.
//   - Handshake with idx==N-1: the beat is done.
// - Back-to-back:
//   - s_h2c_tready = IDLE OR (EMIT & idx==N-1 & m_tready).
//   - A new beat accepted on the final-word handshake loads directly; stays in EMIT with idx=0, no bubble.
//   - Otherwise go to IDLE.
// - Latency: first word has m_tvalid=1 the cycle after the input handshake. Sustained rate is one word per cycle.
// - tkeep all zero:
//   - With tlast=1: emit one word with m_tkeep=0, m_tlast=1 (packet boundary preserved).
//   - With tlast=0: beat dropped, stay IDLE/accepting, no output.
// - Non-contiguous tkeep: forwarded unchanged per chunk; zero chunks below h are still emitted.
// - IN_W==OUT_W: N=1 always; block acts as a one-stage register slice.
// CONFIGURATION
// - DMA_H2C_PARITY_CHECK_EN defined:
//   - On each accepted beat, for every byte i with tkeep[i]=1, expected tparity[i] = ^tdata[8i+7:8i] (even parity).
//   - Any mismatch: parity_err=1 for exactly the cycle after the accept; parity_err_cnt +1, saturating at all-ones.
//   - Data is forwarded regardless.
// - DMA_H2C_PARITY_CHECK_EN undefined:
//   - s_h2c_tparity ignored; no checker logic.
//   - parity_err and parity_err_cnt tied to 0.
// TESTING
// - Full beat: tkeep=all-ones, tlast=1, data bytes 0x00..0x3F
//   -> 8 words, word0=0x0706050403020100, m_tkeep=0xFF each, m_tlast only on word 7.
// - Partial beat: tkeep=0x0000_0000_0000_0FFF, tlast=1
//   -> 2 words, m_tkeep=0xFF then 0x0F, m_tlast=1 on word 1.
// - Backpressure: m_tready toggling 1,0,0,1 on a full beat
//   -> no lost or duplicated words, data stable while stalled; s_h2c_tready=0 until final word.
// - Back-to-back: two full beats, tvalid held, m_tready=1
//   -> 16 consecutive m_tvalid cycles, no bubble between beat0 word7 and beat1 word0.
// - Edge cases:
//   - tkeep=0 with tlast=1 -> one word, m_tkeep=0, m_tlast=1.
//   - tkeep=0 with tlast=0 -> no output.
//   - Reset asserted mid-EMIT (idx=3) -> next cycle m_tvalid=0, then s_h2c_tready=1.
// - Parity (macro defined): byte 5 parity flipped on a kept byte
//   -> parity_err pulse 1 cycle, parity_err_cnt 0->1.
//   - With parity_err_cnt preloaded to 0xFFFF via 65535 errors -> stays 0xFFFF.

Source files
------------

// File: rtl/dma_h2c_axis_downsizer.sv
// dma_h2c_axis_downsizer: splits wide XDMA H2C beats into OUT_W-bit words for narrow user logic.
// Optional per-byte even-parity checker on kept bytes when DMA_H2C_PARITY_CHECK_EN is defined.
module dma_h2c_axis_downsizer #(
  parameter int IN_W  = 512,
  parameter int OUT_W = 64,
  parameter int CNT_W = 16
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [IN_W-1:0]      s_h2c_tdata,
  input  logic [IN_W/8-1:0]    s_h2c_tparity,
  input  logic [IN_W/8-1:0]    s_h2c_tkeep,
  input  logic [IN_W/8-1:0]    s_h2c_tusr,
  input  logic                 s_h2c_tlast,
  input  logic                 s_h2c_tvalid,
  output logic                 s_h2c_tready,
  output logic [OUT_W-1:0]     m_tdata,
  output logic [OUT_W/8-1:0]   m_tkeep,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     parity_err_cnt
);
  localparam int KB = IN_W / 8;
  localparam int OB = OUT_W / 8;
  localparam int NW = IN_W / OUT_W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [IN_W-1:0] data_q, data_d;
  logic [KB-1:0] keep_q, keep_d;
  logic last_q, last_d;
  logic [IW-1:0] idx_q, idx_d, lidx_q, lidx_d, lidx_in;
  logic fin, acc, load;
  logic unused_ok;
  // Last word index is the chunk holding the highest kept byte; zero when nothing is kept.
  always_comb begin
    lidx_in = '0;
    for (int c = 0; c < NW; c++)
      if (|s_h2c_tkeep[c*OB +: OB]) lidx_in = IW'(c);
  end
  assign fin          = (state_q == EMIT) && m_tready && (idx_q == lidx_q);
  assign s_h2c_tready = axi_aresetn && ((state_q == IDLE) || fin);
  assign acc          = s_h2c_tvalid && s_h2c_tready;
  assign load         = acc && ((|s_h2c_tkeep) || s_h2c_tlast);
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    idx_d   = idx_q;
    lidx_d  = lidx_q;
    if (load) begin
      state_d = EMIT;
      data_d  = s_h2c_tdata;
      keep_d  = s_h2c_tkeep;
      last_d  = s_h2c_tlast;
      idx_d   = '0;
      lidx_d  = lidx_in;
    end else if (fin) begin
      state_d = IDLE;
    end else if ((state_q == EMIT) && m_tready) begin
      idx_d = idx_q + IW'(1);
    end
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      lidx_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      lidx_q  <= lidx_d;
    end
  end
  always_comb begin
    m_tdata = '0;
    m_tkeep = '0;
    for (int c = 0; c < NW; c++)
      if (IW'(c) == idx_q) begin
        m_tdata = data_q[c*OUT_W +: OUT_W];
        m_tkeep = keep_q[c*OB +: OB];
      end
  end
  assign m_tvalid = (state_q == EMIT);
  assign m_tlast  = m_tvalid && last_q && (idx_q == lidx_q);
`ifdef DMA_H2C_PARITY_CHECK_EN
  logic perr_q, perr_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [KB-1:0] bad;
  always_comb begin
    bad = '0;
    for (int i = 0; i < KB; i++)
      bad[i] = s_h2c_tkeep[i] && (s_h2c_tparity[i] != ^s_h2c_tdata[8*i +: 8]);
    perr_d = acc && (|bad);
    pcnt_d = (perr_d && (pcnt_q != '1)) ? pcnt_q + CNT_W'(1) : pcnt_q;
  end
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      perr_q <= 1'b0;
      pcnt_q <= '0;
    end else begin
      perr_q <= perr_d;
      pcnt_q <= pcnt_d;
    end
  end
  assign parity_err     = perr_q;
  assign parity_err_cnt = pcnt_q;
  assign unused_ok      = ^s_h2c_tusr;
`else
  assign parity_err     = 1'b0;
  assign parity_err_cnt = '0;
  assign unused_ok      = ^{s_h2c_tusr, s_h2c_tparity};
`endif
endmodule

// File: tb/tb_dma_h2c_axis_downsizer.sv
// tb_dma_h2c_axis_downsizer: directed stimulus with a word scoreboard for dma_h2c_axis_downsizer.
`timescale 1ns/1ps
module tb_dma_h2c_axis_downsizer;
  logic clk = 1'b0;
  logic axi_aresetn;
  logic [511:0] s_h2c_tdata;
  logic [63:0] s_h2c_tparity, s_h2c_tkeep, s_h2c_tusr;
  logic s_h2c_tlast, s_h2c_tvalid, s_h2c_tready;
  logic [63:0] m_tdata;
  logic [7:0] m_tkeep;
  logic m_tlast, m_tvalid, m_tready;
  logic parity_err;
  logic [15:0] parity_err_cnt;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l; logic f;} exp_t;
  exp_t q[$];
  int cmp = 0, errs = 0, wcnt = 0, run = 0, maxrun = 0;
  always #5 clk = ~clk;
  dma_h2c_axis_downsizer dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn),
    .s_h2c_tdata(s_h2c_tdata), .s_h2c_tparity(s_h2c_tparity), .s_h2c_tkeep(s_h2c_tkeep),
    .s_h2c_tusr(s_h2c_tusr), .s_h2c_tlast(s_h2c_tlast), .s_h2c_tvalid(s_h2c_tvalid),
    .s_h2c_tready(s_h2c_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .parity_err(parity_err), .parity_err_cnt(parity_err_cnt));
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    cmp++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  function automatic logic [63:0] goodpar(input logic [511:0] x);
    logic [63:0] p;
    for (int i = 0; i < 64; i++) p[i] = ^x[8*i +: 8];
    return p;
  endfunction
  task automatic push_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int lc = 0;
    exp_t e;
    for (int c = 0; c < 8; c++) if (k[c*8 +: 8] != 8'h00) lc = c;
    if (k == 64'h0 && !l) return;
    for (int c = 0; c <= lc; c++) begin
      e.d = d[c*64 +: 64]; e.k = k[c*8 +: 8]; e.l = l && (c == lc); e.f = (c == lc);
      q.push_back(e);
    end
  endtask
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l, input logic [63:0] flip);
    int n = 0;
    s_h2c_tdata = d; s_h2c_tkeep = k; s_h2c_tlast = l;
    s_h2c_tparity = goodpar(d) ^ flip; s_h2c_tusr = 64'hA5A5_5A5A_0F0F_F0F0;
    s_h2c_tvalid = 1'b1;
    push_beat(d, k, l);
    @(negedge clk);
    while (!s_h2c_tready && n < 200) begin @(negedge clk); n++; end
    chk("accept_timeout", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
  endtask
  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || m_tvalid) && n < 2000) begin @(negedge clk); n++; end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (axi_aresetn) begin
      run = m_tvalid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (m_tvalid) begin
        if (q.size() == 0) chk("sb_word_expected", 64'(q.size()), 64'd1);
        else begin
          chk("m_tdata", m_tdata, q[0].d);
          chk("m_tkeep", 64'(m_tkeep), 64'(q[0].k));
          chk("m_tlast", 64'(m_tlast), 64'(q[0].l));
          chk("s_tready_emit", 64'(s_h2c_tready), 64'(q[0].f & m_tready));
          if (m_tready) begin void'(q.pop_front()); wcnt++; end
        end
      end else chk("s_tready_idle", 64'(s_h2c_tready), 64'd1);
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [511:0] full;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int w0;
    for (int i = 0; i < 64; i++) full[8*i +: 8] = 8'(i);
    axi_aresetn = 1'b0; m_tready = 1'b1; s_h2c_tvalid = 1'b0; s_h2c_tdata = '0;
    s_h2c_tkeep = '0; s_h2c_tparity = '0; s_h2c_tusr = '0; s_h2c_tlast = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_s_tready", 64'(s_h2c_tready), 64'd0);
    chk("rst_parity_err", 64'(parity_err), 64'd0);
    chk("rst_parity_cnt", 64'(parity_err_cnt), 64'd0);
    @(posedge clk); #1;
    axi_aresetn = 1'b1;
    @(negedge clk);
    chk("post_rst_s_tready", 64'(s_h2c_tready), 64'd1);
    @(posedge clk); #1;
    send_beat(full, '1, 1'b1, '0);
    s_h2c_tvalid = 1'b0;
    @(negedge clk);
    chk("full_latency_valid", 64'(m_tvalid), 64'd1);
    chk("full_word0", m_tdata, 64'h0706050403020100);
    @(posedge clk); #1;
    drain();
    send_beat(full, 64'h0000_0000_0000_0FFF, 1'b1, '0);
    s_h2c_tvalid = 1'b0;
    @(negedge clk);
    chk("part_keep0", 64'(m_tkeep), 64'hFF);
    @(negedge clk);
    chk("part_keep1", 64'(m_tkeep), 64'h0F);
    chk("part_last1", 64'(m_tlast), 64'd1);
    @(posedge clk); #1;
    drain();
    w0 = wcnt;
    send_beat(~full, '1, 1'b1, '0);
    s_h2c_tvalid = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      m_tready = pat[i % 4];
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    drain();
    chk("bp_words", 64'(wcnt - w0), 64'd8);
    maxrun = 0; w0 = wcnt;
    send_beat(full, '1, 1'b1, '0);
    send_beat(~full, '1, 1'b0, '0);
    s_h2c_tvalid = 1'b0;
    drain();
    chk("b2b_words", 64'(wcnt - w0), 64'd16);
    chk("b2b_no_bubble", 64'(maxrun), 64'd16);
    send_beat(full, 64'h0, 1'b1, '0);
    s_h2c_tvalid = 1'b0;
    @(negedge clk);
    chk("zk_valid", 64'(m_tvalid), 64'd1);
    chk("zk_keep", 64'(m_tkeep), 64'd0);
    chk("zk_last", 64'(m_tlast), 64'd1);
    @(posedge clk); #1;
    drain();
    w0 = wcnt;
    send_beat(full, 64'h0, 1'b0, '0);
    s_h2c_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop_words", 64'(wcnt - w0), 64'd0);
    chk("drop_valid", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
    w0 = wcnt;
    send_beat(full, '1, 1'b1, '0);
    s_h2c_tvalid = 1'b0;
    for (int i = 0; i < 50 && wcnt - w0 < 3; i++) @(posedge clk);
    #1;
    axi_aresetn = 1'b0;
    @(negedge clk);
    chk("midrst_pre_valid", 64'(m_tvalid), 64'd1);
    @(posedge clk); #1;
    q.delete();
    @(negedge clk);
    chk("midrst_valid", 64'(m_tvalid), 64'd0);
    chk("midrst_tready", 64'(s_h2c_tready), 64'd0);
    @(posedge clk); #1;
    axi_aresetn = 1'b1;
    @(negedge clk);
    chk("midrst_tready_after", 64'(s_h2c_tready), 64'd1);
    chk("midrst_no_word", 64'(m_tvalid), 64'd0);
    @(posedge clk); #1;
`ifdef DMA_H2C_PARITY_CHECK_EN
    send_beat(full, '1, 1'b1, 64'h20);
    s_h2c_tvalid = 1'b0;
    @(negedge clk);
    chk("par_err_pulse", 64'(parity_err), 64'd1);
    chk("par_cnt_1", 64'(parity_err_cnt), 64'd1);
    @(negedge clk);
    chk("par_err_clear", 64'(parity_err), 64'd0);
    @(posedge clk); #1;
    drain();
    for (int i = 0; i < 65540; i++) send_beat(512'h0, 64'h1, 1'b1, 64'h1);
    s_h2c_tvalid = 1'b0;
    drain();
    chk("par_cnt_sat", 64'(parity_err_cnt), 64'hFFFF);
`else
    send_beat(full, '1, 1'b1, 64'h20);
    s_h2c_tvalid = 1'b0;
    @(negedge clk);
    chk("par_off_err", 64'(parity_err), 64'd0);
    chk("par_off_cnt", 64'(parity_err_cnt), 64'd0);
    @(posedge clk); #1;
    drain();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
